bist_sequencer: RTL and testbench



---
 rtl/bist_pkg.sv | 13 +
 rtl/bist_down_counter.sv | 19 +
 rtl/bist_sequencer.sv | 122 ++++++++++++
 tb/tb_bist_sequencer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// bist_pkg: state encoding and parameter limits shared by the BIST sequencer files.
package bist_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    UNLOAD  = 3'd4,
    FINISH  = 3'd5,
    DONE    = 3'd6
  } state_t;
  localparam int CAPTURE_MIN = 1;
endpackage

// File: rtl/bist_down_counter.sv
// bist_down_counter: loadable down counter with a zero flag; holds at zero.
module bist_down_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] count;
  assign zero = count == '0;
  always_ff @(posedge clock) begin
    if (reset) count <= '0;
    else if (load) count <= load_val;
    else if (dec && !zero) count <= count - 1'b1;
  end
endmodule

// File: rtl/bist_sequencer.sv
// bist_sequencer: run-time configurable scan BIST sequencer with abort and pass/fail verdict.
// Define BIST_SIGCHECK_EN to compare misr_sig against golden_sig at the end of a run.
module bist_sequencer
  import bist_pkg::*;
#(
  parameter int SHIFT_W        = 8,
  parameter int PAT_W          = 16,
  parameter int SIG_W          = 16,
  parameter int CAPTURE_CYCLES = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               bist_start,
  input  logic               bist_abort,
  input  logic [SHIFT_W-1:0] cfg_shift_len,
  input  logic [PAT_W-1:0]   cfg_num_patterns,
  input  logic [SIG_W-1:0]   golden_sig,
  input  logic [SIG_W-1:0]   misr_sig,
  output logic               mode,
  output logic               init,
  output logic               running,
  output logic               finish,
  output logic               bist_end,
  output logic               pass,
  output logic               fail,
  output logic [PAT_W-1:0]   pattern_count
);
  localparam int CC = CAPTURE_CYCLES < CAPTURE_MIN ? CAPTURE_MIN : CAPTURE_CYCLES;
  localparam int CW = $clog2(CC + 1);
  state_t             state;
  logic               start_q;
  logic [SHIFT_W-1:0] len_m1;
  logic [PAT_W-1:0]   num_pat;
  logic               shift_zero;
  logic               cap_zero;
  logic               sig_ok;
  logic               start_edge;
  logic               active;
  logic               shifting;
  logic [SHIFT_W-1:0] cfg_len_m1;
  logic [PAT_W-1:0]   cfg_num;
  logic [PAT_W-1:0]   pc_next;
  assign start_edge = bist_start & ~start_q;
  assign active     = state inside {INIT, SHIFT, CAPTURE, UNLOAD, FINISH};
  assign shifting   = state == SHIFT || state == UNLOAD;
  assign cfg_len_m1 = cfg_shift_len == '0 ? '0 : cfg_shift_len - 1'b1;
  assign cfg_num    = cfg_num_patterns == '0 ? PAT_W'(1) : cfg_num_patterns;
  assign pc_next    = pattern_count + 1'b1;
`ifdef BIST_SIGCHECK_EN
  assign sig_ok = misr_sig == golden_sig;
`else
  logic unused_sig;
  assign unused_sig = ^{golden_sig, misr_sig};
  assign sig_ok     = 1'b1;
`endif
  // The shift counter is preloaded outside shifting; the first load comes straight from cfg in INIT.
  bist_down_counter #(.W(SHIFT_W)) u_shift_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (!shifting),
    .dec      (shifting),
    .load_val (state == INIT ? cfg_len_m1 : len_m1),
    .zero     (shift_zero)
  );
  bist_down_counter #(.W(CW)) u_cap_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (state != CAPTURE),
    .dec      (state == CAPTURE),
    .load_val (CW'(CC - 1)),
    .zero     (cap_zero)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      start_q       <= 1'b0;
      len_m1        <= '0;
      num_pat       <= '0;
      pattern_count <= '0;
      pass          <= 1'b0;
      fail          <= 1'b0;
    end else begin
      start_q <= bist_start;
      if (active && bist_abort) begin
        state <= DONE;
        pass  <= 1'b0;
        fail  <= 1'b1;
      end else begin
        case (state)
          IDLE, DONE: if (start_edge) begin
            state         <= INIT;
            pattern_count <= '0;
            pass          <= 1'b0;
            fail          <= 1'b0;
          end
          INIT: begin
            len_m1  <= cfg_len_m1;
            num_pat <= cfg_num;
            state   <= SHIFT;
          end
          SHIFT: state <= shift_zero ? CAPTURE : SHIFT;
          CAPTURE: if (cap_zero) begin
            pattern_count <= pc_next;
            state         <= pc_next == num_pat ? UNLOAD : SHIFT;
          end
          UNLOAD: state <= shift_zero ? FINISH : UNLOAD;
          FINISH: begin
            state <= DONE;
            pass  <= sig_ok;
            fail  <= ~sig_ok;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
  assign mode     = shifting;
  assign init     = state == INIT;
  assign running  = state == SHIFT || state == CAPTURE;
  assign finish   = state == FINISH;
  assign bist_end = state == DONE;
endmodule

// File: tb/tb_bist_sequencer.sv
// tb_bist_sequencer: directed and randomized runs checked against a per-cycle expected output sequence.
module tb_bist_sequencer;
  localparam int C = 1;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        bist_start = 1'b0;
  logic        bist_abort = 1'b0;
  logic [7:0]  cfg_shift_len = '0;
  logic [15:0] cfg_num_patterns = '0;
  logic [15:0] golden_sig = 16'hA5A5;
  logic [15:0] misr_sig = 16'hA5A5;
  logic        mode, init, running, finish, bist_end, pass, fail;
  logic [15:0] pattern_count;
  logic [6:0]  o;
  int          total = 0;
  int          bad = 0;
  assign o = {mode, init, running, finish, bist_end, pass, fail};
  always #5 clock = ~clock;
  bist_sequencer dut (
    .clock            (clock),
    .reset            (reset),
    .bist_start       (bist_start),
    .bist_abort       (bist_abort),
    .cfg_shift_len    (cfg_shift_len),
    .cfg_num_patterns (cfg_num_patterns),
    .golden_sig       (golden_sig),
    .misr_sig         (misr_sig),
    .mode             (mode),
    .init             (init),
    .running          (running),
    .finish           (finish),
    .bist_end         (bist_end),
    .pass             (pass),
    .fail             (fail),
    .pattern_count    (pattern_count)
  );
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Expected outputs per cycle are {mode,init,running,finish,bist_end,pass,fail}, built from L, N and C.
  task automatic run(input int lc, input int nc, input bit sig_ok, input int abort_at,
                     input int rst_at, input bit abort_with_start);
    logic [6:0] e[$];
    int         pc[$];
    int         l, n;
    bit         vp;
    l = lc == 0 ? 1 : lc;
    n = nc == 0 ? 1 : nc;
    e.push_back(7'b0100000);
    pc.push_back(0);
    for (int p = 0; p < n; p++) begin
      repeat (l) begin e.push_back(7'b1010000); pc.push_back(p); end
      repeat (C) begin e.push_back(7'b0010000); pc.push_back(p); end
    end
    repeat (l) begin e.push_back(7'b1000000); pc.push_back(n); end
    e.push_back(7'b0001000);
    pc.push_back(n);
`ifdef BIST_SIGCHECK_EN
    vp = sig_ok;
`else
    vp = 1'b1;
`endif
    misr_sig         = sig_ok ? golden_sig : golden_sig ^ 16'h0001;
    cfg_shift_len    = lc[7:0];
    cfg_num_patterns = nc[15:0];
    bist_start       = 1'b1;
    bist_abort       = abort_with_start;
    step;
    bist_abort = 1'b0;
    for (int i = 0; i < e.size(); i++) begin
      if (i == 0) chk("init_cycle", 32'(o[6:2]), 32'(e[0][6:2]));
      else begin
        chk($sformatf("outs_cyc%0d", i), 32'(o), 32'(e[i]));
        chk($sformatf("pc_cyc%0d", i), 32'(pattern_count), pc[i]);
      end
      if (i == 1) begin
        bist_start       = 1'b0;
        cfg_shift_len    = 8'($urandom);
        cfg_num_patterns = 16'($urandom_range(0, 7));
      end
      if (i == 3) bist_start = 1'b1;
      if (i == 4) bist_start = 1'b0;
      if (i == abort_at) begin
        bist_abort = 1'b1;
        step;
        bist_abort = 1'b0;
        chk("abort_outs", 32'(o), 32'(7'b0000101));
        chk("abort_pc", 32'(pattern_count), pc[i]);
        return;
      end
      if (i == rst_at) begin
        reset      = 1'b1;
        bist_start = 1'b1;
        step;
        chk("midrun_reset_outs", 32'(o), 0);
        chk("midrun_reset_pc", 32'(pattern_count), 0);
        step;
        reset = 1'b0;
        return;
      end
      step;
    end
    chk("done_outs", 32'(o), 32'({5'b00001, vp, ~vp}));
    chk("done_pc", 32'(pattern_count), n);
    step;
    step;
    chk("done_hold_outs", 32'(o), 32'({5'b00001, vp, ~vp}));
    chk("done_hold_pc", 32'(pattern_count), n);
  endtask
  initial begin
    step;
    step;
    chk("reset_outs", 32'(o), 0);
    chk("reset_pc", 32'(pattern_count), 0);
    reset      = 1'b0;
    bist_abort = 1'b1;
    step;
    chk("idle_abort_ignored", 32'(o), 0);
    bist_abort = 1'b0;
    run(4, 3, 1'b1, -1, -1, 1'b0);
    run(4, 3, 1'b0, -1, -1, 1'b0);
    run(0, 0, 1'b1, -1, -1, 1'b0);
    run(8, 5, 1'b1, 12, -1, 1'b0);
    run(4, 2, 1'b1, -1, -1, 1'b1);
    run(4, 3, 1'b1, -1, 5, 1'b0);
    run(4, 3, 1'b1, -1, -1, 1'b0);
    for (int k = 0; k < 6; k++)
      run($urandom_range(0, 6), $urandom_range(0, 4), 1'($urandom_range(0, 1)), -1, -1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
